// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, extracts/extends load data and
// drives the MEM->WB bus plus the MEM forwarding bus back to ID.
module mem_stage #(
  parameter int unsigned EX_TO_MEM_WD = 75,
  parameter int unsigned MEM_TO_WB_WD = 70
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id_fwd
);

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_LB   = 3'b001,
    OP_LBU  = 3'b010,
    OP_LH   = 3'b011,
    OP_LHU  = 3'b100,
    OP_LW   = 3'b101
  } mem_op_e;

  logic [EX_TO_MEM_WD-1:0] stage_q, stage_d;
  logic                    fresh_q, fresh_d;
  logic [31:0]             rdata_q, rdata_d;

  logic [31:0] ex_pc;
  mem_op_e     mem_op;
  logic        data_ram_en;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;

  logic [31:0] rd;
  logic [1:0]  lane;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_res;
  logic [31:0] rf_wdata;
  logic        unused_bits;

  assign ex_pc       = stage_q[74:43];
  assign mem_op      = mem_op_e'(stage_q[42:40]);
  assign data_ram_en = stage_q[39];
  assign sel_rf_res  = stage_q[38];
  assign rf_we       = stage_q[37];
  assign rf_waddr    = stage_q[36:32];
  assign ex_result   = stage_q[31:0];

  // Only MEM/WB stall bits matter here; the request enable is consumed upstream.
  assign unused_bits = ^{data_ram_en, stall[5], stall[2:0]};

  // Zeroing (flush or bubble) and loading both restart the first-cycle window;
  // rdata is captured only on the hold edge that ends that window.
  always_comb begin
    stage_d = stage_q;
    fresh_d = 1'b0;
    rdata_d = rdata_q;
    if (flush || (stall[3] && !stall[4])) begin
      stage_d = '0;
      fresh_d = 1'b1;
    end else if (!stall[3]) begin
      stage_d = ex_to_mem_bus;
      fresh_d = 1'b1;
    end else if (fresh_q) begin
      rdata_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      fresh_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      stage_q <= stage_d;
      fresh_q <= fresh_d;
      rdata_q <= rdata_d;
    end
  end

  assign rd   = fresh_q ? data_sram_rdata : rdata_q;
  assign lane = ex_result[1:0];

  always_comb begin
    byte_v = rd[7:0];
    case (lane)
      2'd0: byte_v = rd[7:0];
      2'd1: byte_v = rd[15:8];
      2'd2: byte_v = rd[23:16];
      2'd3: byte_v = rd[31:24];
      default: byte_v = rd[7:0];
    endcase
  end

  assign half_v = lane[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    load_res = '0;
    case (mem_op)
      OP_LB:   load_res = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_res = {24'd0, byte_v};
      OP_LH:   load_res = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_res = {16'd0, half_v};
      OP_LW:   load_res = rd;
      default: load_res = '0;
    endcase
  end

  assign rf_wdata = sel_rf_res ? load_res : ex_result;

  assign mem_to_wb_bus = {ex_pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_id_fwd = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, ALU pass-through, load
// extraction, stall hold, bubble, flush priority, reset mid-stall.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic [74:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_fwd;

  int unsigned checks;
  int unsigned errors;

  mem_stage #(.EX_TO_MEM_WD(75), .MEM_TO_WB_WD(70)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_fwd   (mem_to_id_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [74:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                     input logic ren, input logic sel, input logic we,
                                     input logic [4:0] waddr, input logic [31:0] res);
    return {pc, op, ren, sel, we, waddr, res};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    stall = 6'b0;
    ex_to_mem_bus = mk(32'h12345678, 3'b101, 1'b1, 1'b1, 1'b1, 5'd9, 32'h00000004);
    data_sram_rdata = 32'hA5A5A5A5;
    step();
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL reset_wb: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    checks++;
    if (mem_to_id_fwd !== 38'd0) begin
      errors++;
      $display("FAIL reset_fwd: got %h expected %h", mem_to_id_fwd, 38'd0);
    end
    rst = 1'b0;
    ex_to_mem_bus = '0;
    step();
  endtask

  task automatic test_alu();
    logic [69:0] exp_wb;
    ex_to_mem_bus = mk(32'hBFC00010, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 32'h00001234);
    data_sram_rdata = 32'hFFFFFFFF;
    step();
    exp_wb = {32'hBFC00010, 1'b1, 5'd5, 32'h00001234};
    checks++;
    if (mem_to_wb_bus !== exp_wb) begin
      errors++;
      $display("FAIL alu_wb: got %h expected %h", mem_to_wb_bus, exp_wb);
    end
    checks++;
    if (mem_to_id_fwd !== {1'b1, 5'd5, 32'h00001234}) begin
      errors++;
      $display("FAIL alu_fwd: got %h expected %h", mem_to_id_fwd, {1'b1, 5'd5, 32'h00001234});
    end
  endtask

  task automatic test_load_extract();
    logic [2:0]  ops  [10] = '{3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101,
                               3'b011, 3'b100, 3'b010, 3'b001};
    logic [1:0]  adrs [10] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd2, 2'd0, 2'd3};
    logic [31:0] exps [10] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                               32'h00007F01, 32'h80FF7F01, 32'hFFFF80FF, 32'h000080FF,
                               32'h00000001, 32'hFFFFFF80};
    for (int i = 0; i < 10; i++) begin
      ex_to_mem_bus = mk(32'h80000100 + i, ops[i], 1'b1, 1'b1, 1'b1, 5'd3,
                         {30'h04000000, adrs[i]});
      data_sram_rdata = 32'h80FF7F01;
      step();
      checks++;
      if (mem_to_wb_bus[31:0] !== exps[i]) begin
        errors++;
        $display("FAIL load_%0d op=%b a=%0d: got %h expected %h",
                 i, ops[i], adrs[i], mem_to_wb_bus[31:0], exps[i]);
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [69:0] exp_wb;
    ex_to_mem_bus = mk(32'h00400020, 3'b101, 1'b1, 1'b1, 1'b1, 5'd7, 32'h00001000);
    stall = 6'b0;
    data_sram_rdata = 32'hCAFEF00D;
    step();
    exp_wb = {32'h00400020, 1'b1, 5'd7, 32'hCAFEF00D};
    checks++;
    if (mem_to_wb_bus !== exp_wb) begin
      errors++;
      $display("FAIL stall_hold_c0: got %h expected %h", mem_to_wb_bus, exp_wb);
    end
    stall = 6'b011000;
    ex_to_mem_bus = mk(32'h00400024, 3'b000, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0BADBAD0);
    for (int c = 1; c <= 3; c++) begin
      step();
      data_sram_rdata = 32'hDEADBEEF + c;
      #1;
      checks++;
      if (mem_to_wb_bus !== exp_wb) begin
        errors++;
        $display("FAIL stall_hold_c%0d: got %h expected %h", c, mem_to_wb_bus, exp_wb);
      end
    end
  endtask

  task automatic test_bubble();
    stall = 6'b001000;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0 || mem_to_id_fwd[37] !== 1'b0) begin
      errors++;
      $display("FAIL bubble: got wb=%h fwd_we=%b expected wb=0 fwd_we=0",
               mem_to_wb_bus, mem_to_id_fwd[37]);
    end
    stall = 6'b0;
  endtask

  task automatic test_nonload_ignores_rdata();
    ex_to_mem_bus = mk(32'h00400100, 3'b000, 1'b0, 1'b0, 1'b1, 5'd11, 32'h55AA55AA);
    data_sram_rdata = 32'h11111111;
    step();
    stall = 6'b011000;
    step();
    data_sram_rdata = 32'h22222222;
    step();
    checks++;
    if (mem_to_wb_bus[31:0] !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL nonload_rdata: got %h expected %h", mem_to_wb_bus[31:0], 32'h55AA55AA);
    end
    stall = 6'b0;
  endtask

  task automatic test_flush();
    ex_to_mem_bus = mk(32'h00400200, 3'b000, 1'b0, 1'b0, 1'b1, 5'd12, 32'h00000042);
    step();
    checks++;
    if (mem_to_id_fwd !== {1'b1, 5'd12, 32'h00000042}) begin
      errors++;
      $display("FAIL flush_pre: got %h expected %h", mem_to_id_fwd, {1'b1, 5'd12, 32'h00000042});
    end
    flush = 1'b1;
    stall = 6'b011111;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL flush_priority: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    flush = 1'b0;
    stall = 6'b0;
  endtask

  task automatic test_back_to_back();
    ex_to_mem_bus = mk(32'h00400300, 3'b100, 1'b1, 1'b1, 1'b1, 5'd1, 32'h00000002);
    data_sram_rdata = 32'h9876ABCD;
    step();
    checks++;
    if (mem_to_wb_bus[31:0] !== 32'h00009876) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", mem_to_wb_bus[31:0], 32'h00009876);
    end
    ex_to_mem_bus = mk(32'h00400304, 3'b001, 1'b1, 1'b1, 1'b1, 5'd2, 32'h00000000);
    data_sram_rdata = 32'h000000F0;
    step();
    checks++;
    if (mem_to_wb_bus !== {32'h00400304, 1'b1, 5'd2, 32'hFFFFFFF0}) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", mem_to_wb_bus,
               {32'h00400304, 1'b1, 5'd2, 32'hFFFFFFF0});
    end
  endtask

  task automatic test_reset_mid_stall();
    ex_to_mem_bus = mk(32'h00400400, 3'b101, 1'b1, 1'b1, 1'b1, 5'd4, 32'h00000000);
    data_sram_rdata = 32'h13572468;
    step();
    stall = 6'b011000;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    data_sram_rdata = 32'hFFFF0000;
    step();
    checks++;
    if (mem_to_wb_bus !== 70'd0) begin
      errors++;
      $display("FAIL reset_mid_stall: got %h expected %h", mem_to_wb_bus, 70'd0);
    end
    stall = 6'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu();
    test_load_extract();
    test_stall_hold();
    test_bubble();
    test_nonload_ignores_rdata();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the 5-stage CPU, between EX and WB. Registers the EX→MEM bus and takes the data-SRAM read data, which arrives one cycle after EX issued the request. Extracts and extends byte/half/word load results and produces the 70-bit MEM→WB bus plus a forwarding bus to ID. Holds the captured read data across pipeline stalls so a stalled load never picks up a later SRAM response.

## Interface
- `EX_TO_MEM_WD`, 75: bus layout, MSB first:
  - `ex_pc[31:0]`
  - `mem_op[2:0]`: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, others treated as none
  - `data_ram_en`
  - `sel_rf_res`: 1 = write-back value is load data
  - `rf_we`
  - `rf_waddr[4:0]`
  - `ex_result[31:0]`: ALU result or load byte address
- `MEM_TO_WB_WD`, 70: `{mem_pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}`.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: squash the stage register.
- `stall` in 6: pipeline stall vector, 1 = Stop. This stage uses `stall[3]` (MEM) and `stall[4]` (WB).
- `ex_to_mem_bus` in 75: EX outputs.
- `data_sram_rdata` in 32: SRAM read data. Valid only in the first cycle a load occupies MEM.
- `mem_to_wb_bus` out 70: to WB.
- `mem_to_id_fwd` out 38: `{rf_we, rf_waddr, rf_wdata}` of the instruction currently in MEM.

## Operation
- Stage register `ex_to_mem_bus_r`. Priority on each edge:
  1. `rst` → 0.
  2. `flush` → 0.
  3. `stall[3]`=1 and `stall[4]`=0 → 0 (bubble into MEM).
  4. `stall[3]`=0 → load `ex_to_mem_bus`.
  5. Otherwise hold.
- First-cycle flag `fresh`:
  - Set to 1 on every edge that loads or zeroes the stage register.
  - Cleared to 0 on a hold edge.
  - Reset value 0.
- Read-data capture `rdata_q[31:0]`:
  - On an edge where `fresh`=1 and the stage register holds, `rdata_q <= data_sram_rdata`.
  - Otherwise `rdata_q` is unchanged.
  - Reset value 0.
- Effective read data `rd` = `fresh` ? `data_sram_rdata` : `rdata_q`.
- Lane select `a` = `ex_result[1:0]`:
  - LB/LBU: byte `rd[8a+7:8a]`, sign- or zero-extended.
  - LH/LHU: `a[1]`=0 → `rd[15:0]`; `a[1]`=1 → `rd[31:16]`, sign- or zero-extended. `a[0]` is ignored; misalignment is trapped upstream.
  - LW: `rd`.
- `rf_wdata` = `sel_rf_res` ? load result : `ex_result`.
- `mem_pc` = `ex_pc`. `rf_we` and `rf_waddr` pass through unchanged.
- Outputs are combinational from the stage register, `fresh`, `rdata_q` and `data_sram_rdata`.
- A zeroed register yields `rf_we`=0, so it is a bubble to WB and to forwarding.

## Timing
- Latency: an instruction accepted on edge N is visible on `mem_to_wb_bus` from N until the next load/zero edge. WB samples it on the edge after N if WB is not stalled.
- Reset: all outputs are 0 in the cycle after `rst` is sampled high. `data_sram_rdata` still drives `rf_wdata` only when `sel_rf_res`=1, which it is not after reset.
- Stall held for k cycles with the same load in MEM: `rf_wdata` is identical in every cycle (the first from live `data_sram_rdata`, the rest from `rdata_q`) even if `data_sram_rdata` changes.
- `flush` together with any stall pattern: `flush` wins, giving a bubble.
- `rst` mid-stall: register, `fresh` and `rdata_q` clear on that edge.
- Non-load instructions never use `rd`. SRAM data changes have no effect on their output.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with a nonzero `ex_to_mem_bus` → `mem_to_wb_bus`=0 and `mem_to_id_fwd`=0 in the cycle after reset.
- ALU pass-through: pc=0xBFC00010, `rf_we`=1, waddr=5, `ex_result`=0x1234, `sel_rf_res`=0, no stall → next cycle `mem_to_wb_bus` = {0xBFC00010, 1, 5, 0x00001234}.
- Load extraction with `data_sram_rdata`=0x80FF7F01:
  - LB addr ..1 → 0x0000007F
  - LB addr ..2 → 0xFFFFFFFF
  - LBU addr ..3 → 0x00000080
  - LH addr ..2 → 0xFFFF80FF
  - LHU addr ..0 → 0x00007F01
  - LW → 0x80FF7F01
- Stall hold: LW enters with rdata 0xCAFEF00D, then `stall[4:3]`=11 for 3 cycles while `data_sram_rdata` changes to 0xDEADBEEF → `rf_wdata` stays 0xCAFEF00D in all 4 cycles.
- Bubble insert: `stall[3]`=1, `stall[4]`=0 → next cycle bus is 0 and `rf_we`=0.
- Flush priority: `flush`=1 with `stall`=6'b011111 → bus becomes 0 on that edge.
